counter_run_ctrl: RTL

//  Run controller for the N-bit up-counter (ports clk/reset/enable/count).

---
 rtl/counter_ctrl_pkg.sv | 14 +
 rtl/counter_run_ctrl.sv | 82 ++++++++
 2 files changed

// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared state encoding and default widths for counter_run_ctrl
package counter_ctrl_pkg;

    localparam int DEF_N      = 8;
    localparam int DEF_RUNS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - run controller for an N-bit up-counter: clear, count to target, pulse done
// Optional COUNTER_AUTO_RELOAD_EN: DONE returns to CLEAR so runs repeat until stop.
module counter_run_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int RUNS_W = DEF_RUNS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [N-1:0]      target,
    input  logic [N-1:0]      count,
    output logic              cnt_rst_n,
    output logic              cnt_en,
    output logic              busy,
    output logic              done,
    output logic [RUNS_W-1:0] runs
);

    state_t          state;
    state_t          next_state;
    logic [N-1:0]    target_q;
    logic            at_target;
    logic            accept;

    assign at_target = (count == target_q);
    assign accept    = (state == ST_IDLE) && (next_state == ST_CLEAR);

    always_comb begin
        next_state = state;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                next_state = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // Enable is not gated by stop: the counter may advance on the abort edge.
                cnt_en = !pause && !at_target;
                if (stop)                       next_state = ST_IDLE;
                else if (at_target && !pause)   next_state = ST_DONE;
            end
            ST_DONE: begin
`ifdef COUNTER_AUTO_RELOAD_EN
                next_state = stop ? ST_IDLE : ST_CLEAR;
`else
                next_state = ST_IDLE;
`endif
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            target_q  <= '0;
            runs      <= '0;
            cnt_rst_n <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            cnt_rst_n <= (next_state != ST_CLEAR);
            done      <= (next_state == ST_DONE);
            busy      <= (next_state != ST_IDLE);
            if (accept) begin
                target_q <= target;
                runs     <= '0;
            end else if ((state == ST_DONE) && (runs != '1)) begin
                runs <= runs + RUNS_W'(1);
            end
        end
    end

endmodule
